// File: rtl/antirebote_pulsadores.sv
// ============================================================================
// Module   : antirebote_pulsadores
// Purpose  : 5-channel push-button debouncer with press strobes and optional
//            auto-repeat (define AUTOREPEAT_EN to enable on channels 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module antirebote_pulsadores #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned REP_DELAY  = 50000000,
  parameter int unsigned REP_PERIOD = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse,
  output logic       btn_any
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || REP_PERIOD < 2 || REP_DELAY < 1) begin : g_param_check
    $error("antirebote_pulsadores: illegal DEB_CYCLES/REP_DELAY/REP_PERIOD");
  end

  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;
  logic [4:0] s;
  logic [4:0] pulse_d_vec;
  logic [4:0] pulse_q_vec;
  logic [4:0] level_q_vec;
  logic       btn_any_q, btn_any_d;

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    btn_any_d = |pulse_d_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      btn_any_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      btn_any_q <= btn_any_d;
    end
  end

  assign s = sync2_q;

  for (genvar i = 0; i < 5; i++) begin : g_ch
    state_t      state_q, state_d;
    logic [31:0] deb_q, deb_d;
    logic        level_q, level_d;
    logic        pulse_q, pulse_d;
`ifdef AUTOREPEAT_EN
    // Only the up/down buttons scroll; the others stay in HELD until release.
    localparam bit REP_EN = (i < 2);
    localparam logic [31:0] REP_DLY_LAST = 32'(REP_DELAY - 1);
    localparam logic [31:0] REP_PER_LAST = 32'(REP_PERIOD - 1);
    logic [31:0] rep_q, rep_d;
`endif

    always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      level_d = level_q;
      pulse_d = 1'b0;
`ifdef AUTOREPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
        IDLE: begin
          level_d = 1'b0;
          if (s[i]) begin
            state_d = DEB_PRESS;
            deb_d   = '0;
          end
        end
        DEB_PRESS: begin
          if (!s[i]) begin
            state_d = IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = HELD;
            level_d = 1'b1;
            pulse_d = 1'b1;
            deb_d   = '0;
`ifdef AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            deb_d = deb_q + 32'd1;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d = DEB_RELEASE;
            deb_d   = '0;
          end
`ifdef AUTOREPEAT_EN
          else if (REP_EN) begin
            if (rep_q == REP_DLY_LAST) begin
              state_d = REPEAT;
              pulse_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + 32'd1;
            end
          end
`endif
        end
`ifdef AUTOREPEAT_EN
        REPEAT: begin
          if (!s[i]) begin
            state_d = DEB_RELEASE;
            deb_d   = '0;
          end else if (rep_q == REP_PER_LAST) begin
            pulse_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 32'd1;
          end
        end
`endif
        DEB_RELEASE: begin
          // A bounce back high resumes the hold without a new press strobe.
          if (s[i]) begin
            state_d = HELD;
            deb_d   = '0;
`ifdef AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else if (deb_q == DEB_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 32'd1;
          end
        end
        default: begin
          state_d = IDLE;
          deb_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        deb_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
`ifdef AUTOREPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
`ifdef AUTOREPEAT_EN
        rep_q   <= rep_d;
`endif
      end
    end

    assign pulse_d_vec[i] = pulse_d;
    assign pulse_q_vec[i] = pulse_q;
    assign level_q_vec[i] = level_q;
  end

  assign btn_level = level_q_vec;
  assign btn_pulse = pulse_q_vec;
  assign btn_any   = btn_any_q;

endmodule

`default_nettype wire

// File: tb/tb_antirebote_pulsadores.sv
// ============================================================================
// Module   : tb_antirebote_pulsadores
// Purpose  : Directed-vector bench for antirebote_pulsadores (DEB=4, REP 10/5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_antirebote_pulsadores;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_in = '0;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       btn_any;
  int         n_vec = 0;
  int         n_err = 0;

  antirebote_pulsadores #(
    .DEB_CYCLES (4),
    .REP_DELAY  (10),
    .REP_PERIOD (5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_any   (btn_any)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] lvl, input logic [4:0] pls);
    check_eq({tag, "_lvl"}, {27'd0, btn_level}, {27'd0, lvl});
    check_eq({tag, "_pls"}, {27'd0, btn_pulse}, {27'd0, pls});
    check_eq({tag, "_any"}, {31'd0, btn_any},   {31'd0, |pls});
  endtask

  initial begin
    logic [4:0] ep;
    logic [4:0] el;

    // Reset state
    rst_n = 1'b0;
    step(); step(); step();
    check_outs("reset", 5'd0, 5'd0);
    rst_n = 1'b1;
    step(); step();

    // Channel 2 press: strobe only after edge 6, level from then on
    btn_in = 5'b00100;
    for (int k = 0; k <= 10; k++) begin
      step();
      check_outs($sformatf("t1_press_k%0d", k), (k >= 6) ? 5'b00100 : 5'd0,
                 (k == 6) ? 5'b00100 : 5'd0);
    end
    btn_in = 5'd0;
    for (int k = 0; k <= 8; k++) begin
      step();
      check_outs($sformatf("t1_rel_k%0d", k), (k < 6) ? 5'b00100 : 5'd0, 5'd0);
    end

    // Channel 0 bounce 1,0,1,0 then steady high: single strobe after edge 10
    for (int k = 0; k <= 14; k++) begin
      btn_in[0] = (k == 1 || k == 3) ? 1'b0 : 1'b1;
      step();
      check_outs($sformatf("t2_k%0d", k), (k >= 10) ? 5'b00001 : 5'd0,
                 (k == 10) ? 5'b00001 : 5'd0);
    end
    btn_in = 5'd0;
    for (int k = 0; k < 10; k++) step();
    check_outs("t2_idle", 5'd0, 5'd0);

    // Channels 1 and 4 held 40 cycles; only channel 1 may auto-repeat
    for (int k = 0; k <= 49; k++) begin
      btn_in = (k < 40) ? 5'b10010 : 5'd0;
      step();
      ep = (k == 6) ? 5'b10010 : 5'd0;
`ifdef AUTOREPEAT_EN
      if (k >= 16 && k <= 41 && ((k - 16) % 5) == 0) ep[1] = 1'b1;
`endif
      el = (k >= 6 && k < 46) ? 5'b10010 : 5'd0;
      check_outs($sformatf("t3_k%0d", k), el, ep);
    end

    // Channel 3 release with a 2-cycle high glitch after 2 low cycles
    btn_in = 5'b01000;
    for (int k = 0; k <= 7; k++) begin
      step();
      check_outs($sformatf("t4_press_k%0d", k), (k >= 6) ? 5'b01000 : 5'd0,
                 (k == 6) ? 5'b01000 : 5'd0);
    end
    for (int k = 0; k <= 13; k++) begin
      btn_in[3] = (k == 2 || k == 3) ? 1'b1 : 1'b0;
      step();
      check_outs($sformatf("t4_rel_k%0d", k), (k < 10) ? 5'b01000 : 5'd0, 5'd0);
    end

    // Reset during press debounce on channels 0 and 3, channel 2 already held
    btn_in = 5'b00100;
    for (int k = 0; k <= 7; k++) step();
    check_outs("t5_pre", 5'b00100, 5'd0);
    btn_in = 5'b01101;
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    check_outs("t5_rst_now", 5'd0, 5'd0);
    step(); step();
    check_outs("t5_rst_hold", 5'd0, 5'd0);
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      check_outs($sformatf("t5_post_k%0d", k), (k >= 6) ? 5'b01101 : 5'd0,
                 (k == 6) ? 5'b01101 : 5'd0);
    end
    btn_in = 5'd0;
    for (int k = 0; k < 10; k++) step();
    check_outs("t5_idle", 5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
